fp_wb_arbiter: RTL and testbench

FP writeback arbiter: merges results from the single-cycle-issue pipelined FP unit and the variable-latency iterative FP unit (div/sqrt) into the single write port of the FP register file. Slow-unit results are buffered in a small FIFO and drained whenever the pipelined unit is not writing. A 32-bit pending scoreboard of FP registers awaiting slow-unit results is kept here for the decode stage's hazard checks. The block sits directly upstream of the FP register file and drives its write-enable, destination and write-data inputs from registers.

---
 rtl/fp_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_fp_wb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - FP writeback arbiter: pipelined/slow result merge, slow FIFO, pending scoreboard
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   Fp_pipe_*_pi            pipelined FP unit result (always accepted)
//   Fp_slow_*_pi/_po        iterative FP unit result with ready handshake
//   Fp_issue_*_pi           decode issue of a slow op (sets scoreboard bit)
//   Fp_pending_po           per-register "awaiting slow result" scoreboard
//   Fp_pipe_stall_po        hold off pipelined issue while the FIFO is near full
//   Fp_we_po/destReg/writeData  registered FP register-file write port
//   Fp_fifo_count_po        slow-result FIFO occupancy
module fp_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Fp_pipe_valid_pi,
  input  logic [4:0]    Fp_pipe_dest_pi,
  input  logic [31:0]   Fp_pipe_data_pi,
  input  logic          Fp_slow_valid_pi,
  output logic          Fp_slow_ready_po,
  input  logic [4:0]    Fp_slow_dest_pi,
  input  logic [31:0]   Fp_slow_data_pi,
  input  logic          Fp_issue_slow_pi,
  input  logic [4:0]    Fp_issue_dest_pi,
  output logic [31:0]   Fp_pending_po,
  output logic          Fp_pipe_stall_po,
  output logic          Fp_we_po,
  output logic [4:0]    Fp_destReg_po,
  output logic [31:0]   Fp_writeData_po,
  output logic [CW-1:0] Fp_fifo_count_po
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_CNT = CW'(DEPTH - 1);

  logic [4:0]    fifo_dest [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic [4:0]    head_dest;
  logic [31:0]   head_data;
  logic [31:0]   pending_nxt;

  assign head_dest = fifo_dest[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Ready and stall look only at the registered count, so a full FIFO
  // refuses a push even in a cycle where it also drains an entry.
  assign Fp_slow_ready_po = reset && (count != FULL_CNT);
  assign Fp_pipe_stall_po = reset && (count >= NEAR_CNT);
  assign Fp_fifo_count_po = count;

  assign push = Fp_slow_valid_pi && Fp_slow_ready_po;
  // The pipelined unit has no backpressure, so it always wins the write port.
  assign pop  = !Fp_pipe_valid_pi && (count != '0);

  // Clear for the drained entry first, then set for a new issue, so that a
  // same-cycle set/clear of one register leaves it pending.
  always_comb begin
    pending_nxt = Fp_pending_po;
    if (pop) begin
      pending_nxt[head_dest] = 1'b0;
    end
    if (Fp_issue_slow_pi) begin
      pending_nxt[Fp_issue_dest_pi] = 1'b1;
    end
  end

  // Storage needs no reset: entries are only readable once pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= Fp_slow_dest_pi;
      fifo_data[wr_ptr] <= Fp_slow_data_pi;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      Fp_pending_po   <= '0;
      Fp_we_po        <= 1'b0;
      Fp_destReg_po   <= '0;
      Fp_writeData_po <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      Fp_pending_po <= pending_nxt;

      if (Fp_pipe_valid_pi) begin
        Fp_we_po        <= 1'b1;
        Fp_destReg_po   <= Fp_pipe_dest_pi;
        Fp_writeData_po <= Fp_pipe_data_pi;
      end else if (pop) begin
        Fp_we_po        <= 1'b1;
        Fp_destReg_po   <= head_dest;
        Fp_writeData_po <= head_data;
      end else begin
        // Idle: drop the enable, leave the last destination/data on the bus.
        Fp_we_po <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - randomized and directed bench for fp_wb_arbiter against a queue-based model
module tb_fp_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pipe_valid = 1'b0;
  logic [4:0]    pipe_dest = '0;
  logic [31:0]   pipe_data = '0;
  logic          slow_valid = 1'b0;
  logic          slow_ready;
  logic [4:0]    slow_dest = '0;
  logic [31:0]   slow_data = '0;
  logic          issue = 1'b0;
  logic [4:0]    issue_dest = '0;
  logic [31:0]   pending;
  logic          stall;
  logic          we;
  logic [4:0]    dest_reg;
  logic [31:0]   wdata;
  logic [CW-1:0] fcount;

  fp_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .Fp_pipe_valid_pi (pipe_valid),
    .Fp_pipe_dest_pi  (pipe_dest),
    .Fp_pipe_data_pi  (pipe_data),
    .Fp_slow_valid_pi (slow_valid),
    .Fp_slow_ready_po (slow_ready),
    .Fp_slow_dest_pi  (slow_dest),
    .Fp_slow_data_pi  (slow_data),
    .Fp_issue_slow_pi (issue),
    .Fp_issue_dest_pi (issue_dest),
    .Fp_pending_po    (pending),
    .Fp_pipe_stall_po (stall),
    .Fp_we_po         (we),
    .Fp_destReg_po    (dest_reg),
    .Fp_writeData_po  (wdata),
    .Fp_fifo_count_po (fcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0;
    slow_valid = 1'b0;
    issue      = 1'b0;
  endtask

  // One clock with the currently driven inputs; the model applies the
  // writeback rules to the queue and then all outputs are compared.
  task automatic step(input string tag);
    bit   m_ready;
    bit   m_stall;
    bit   do_push;
    ent_t e;
    m_ready = (q.size() != DEPTH);
    m_stall = (q.size() >= DEPTH - 1);
    chk({tag, ".ready"}, {31'd0, slow_ready}, {31'd0, m_ready});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall});
    do_push = slow_valid && m_ready;
    if (pipe_valid) begin
      m_we = 1'b1; m_dest = pipe_dest; m_data = pipe_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_dest = e.dest; m_data = e.data;
      m_pend[e.dest] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (issue) m_pend[issue_dest] = 1'b1;
    if (do_push) begin
      e.dest = slow_dest; e.data = slow_data;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, ".we"},      {31'd0, we},      {31'd0, m_we});
    chk({tag, ".dest"},    {27'd0, dest_reg}, {27'd0, m_dest});
    chk({tag, ".data"},    wdata,             m_data);
    chk({tag, ".count"},   {{(32-CW){1'b0}}, fcount}, q.size());
    chk({tag, ".pending"}, pending,           m_pend);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    pipe_valid = 1'b1; slow_valid = 1'b1; issue = 1'b1;
    pipe_dest = 5'd9; slow_dest = 5'd10; issue_dest = 5'd11;
    q.delete();
    m_we = 1'b0; m_dest = '0; m_data = '0; m_pend = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".rst_we"},    {31'd0, we}, 32'd0);
      chk({tag, ".rst_dest"},  {27'd0, dest_reg}, 32'd0);
      chk({tag, ".rst_data"},  wdata, 32'd0);
      chk({tag, ".rst_count"}, {{(32-CW){1'b0}}, fcount}, 32'd0);
      chk({tag, ".rst_pend"},  pending, 32'd0);
      chk({tag, ".rst_ready"}, {31'd0, slow_ready}, 32'd0);
      chk({tag, ".rst_stall"}, {31'd0, stall}, 32'd0);
    end
    reset = 1'b1;
    idle_inputs();
    #1;
    chk({tag, ".rel_ready"}, {31'd0, slow_ready}, 32'd1);
    chk({tag, ".rel_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    m_we = 1'b0; m_dest = '0; m_data = '0; m_pend = '0;
    #2;
    do_reset("reset");

    // Pipelined path: one-cycle latency, destination held when idle.
    pipe_valid = 1'b1; pipe_dest = 5'd3; pipe_data = 32'h3F80_0000;
    step("pipe");
    chk("pipe.dest3", {27'd0, dest_reg}, 32'd3);
    idle_inputs();
    step("pipe_idle");
    chk("pipe_idle.hold", {27'd0, dest_reg}, 32'd3);

    // Slow path with scoreboard: issue, push, write two cycles after push.
    issue = 1'b1; issue_dest = 5'd7;
    step("issue7");
    chk("issue7.bit", {31'd0, pending[7]}, 32'd1);
    idle_inputs();
    slow_valid = 1'b1; slow_dest = 5'd7; slow_data = 32'h4049_0FDB;
    step("slow_push");
    idle_inputs();
    step("slow_pop");
    chk("slow_pop.we", {31'd0, we}, 32'd1);
    chk("slow_pop.pend7", {31'd0, pending[7]}, 32'd0);
    step("slow_idle");

    // Fill the FIFO while the pipelined unit owns the port.
    pipe_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pipe_dest = 5'(i); pipe_data = 32'h1000 + i;
      slow_valid = 1'b1; slow_dest = 5'(20 + i); slow_data = 32'hA000 + i;
      step("fill");
    end
    chk("fill.count4", {{(32-CW){1'b0}}, fcount}, 32'd4);
    chk("fill.ready0", {31'd0, slow_ready}, 32'd0);
    chk("fill.stall1", {31'd0, stall}, 32'd1);
    // Full FIFO refuses a push even while it pops in the same cycle.
    pipe_valid = 1'b0; slow_valid = 1'b1; slow_dest = 5'd30; slow_data = 32'hDEAD;
    step("drain_full");
    slow_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("drain");
    chk("drain.empty", {{(32-CW){1'b0}}, fcount}, 32'd0);

    // Push/pop collision keeps count at one and preserves order.
    slow_valid = 1'b1; slow_dest = 5'd1; slow_data = 32'h1111;
    step("coll_a");
    slow_dest = 5'd2; slow_data = 32'h2222;
    step("coll_b");
    chk("coll_b.count1", {{(32-CW){1'b0}}, fcount}, 32'd1);
    idle_inputs();
    step("coll_c");
    chk("coll_c.dest2", {27'd0, dest_reg}, 32'd2);

    // Set wins over clear on the same register.
    issue = 1'b1; issue_dest = 5'd5;
    slow_valid = 1'b1; slow_dest = 5'd5; slow_data = 32'h5555;
    step("race_a");
    slow_valid = 1'b0;
    step("race_b");
    chk("race_b.pend5", {31'd0, pending[5]}, 32'd1);
    idle_inputs();
    step("race_c");

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("mid_reset");
      pipe_valid = ($urandom_range(0, 99) < 45);
      pipe_dest  = 5'($urandom);
      pipe_data  = $urandom;
      slow_valid = ($urandom_range(0, 99) < 50);
      slow_dest  = 5'($urandom);
      slow_data  = $urandom;
      issue      = ($urandom_range(0, 99) < 30);
      issue_dest = 5'($urandom);
      step("rand");
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) step("flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
